// File: rtl/regfile_if.sv
// Register-file access bus: one write port and two independent read ports.
interface regfile_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ctrl_writeEnable;
  logic [4:0]            ctrl_writeReg;
  logic [4:0]            ctrl_readRegA;
  logic [4:0]            ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;

  // Pipeline side: issues write/read requests and consumes read data.
  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output ctrl_readRegA,
    output ctrl_readRegB,
    output data_writeReg,
    input  data_readRegA,
    input  data_readRegB
  );

  // Register-file side.
  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  ctrl_readRegA,
    input  ctrl_readRegB,
    input  data_writeReg,
    output data_readRegA,
    output data_readRegB
  );
endinterface

// File: rtl/regfile.sv
// 32-entry register file with hardwired-zero register 0, single-edge writes and two
// combinational read ports. Reset clears every entry asynchronously.
module regfile #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic      clock,
  input  logic      ctrl_reset,
  regfile_if.slave  bus
);

  localparam int unsigned Regs = 32;

  logic [DATA_WIDTH-1:0] regs_q [Regs];

  // Register storage: async clear, one write per rising edge, index 0 never written.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < Regs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.ctrl_writeEnable && (bus.ctrl_writeReg != 5'd0)) begin
      regs_q[bus.ctrl_writeReg] <= bus.data_writeReg;
    end
  end

  // Combinational reads with no write bypass; index 0 is forced to zero.
  always_comb begin
    bus.data_readRegA = '0;
    bus.data_readRegB = '0;
    if (bus.ctrl_readRegA != 5'd0) begin
      bus.data_readRegA = regs_q[bus.ctrl_readRegA];
    end
    if (bus.ctrl_readRegB != 5'd0) begin
      bus.data_readRegB = regs_q[bus.ctrl_readRegB];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed corner cases plus randomized traffic against
// an array-based reference model.
module tb_regfile;

  logic clock;
  logic ctrl_reset;

  regfile_if #(.DATA_WIDTH(32)) bus ();

  regfile #(.DATA_WIDTH(32)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_err;
  logic [31:0] model [32];

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : model[idx];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endfunction

  // One cycle, entered and left at a falling edge: drive, check pre-edge reads,
  // take the rising edge, apply the write to the model.
  task automatic cycle(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input string tag);
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeReg    = wr;
    bus.data_writeReg    = wd;
    bus.ctrl_readRegA    = ra;
    bus.ctrl_readRegB    = rb;
    #1;
    check({tag, "_a"}, bus.data_readRegA, model_read(ra));
    check({tag, "_b"}, bus.data_readRegB, model_read(rb));
    @(posedge clock);
    if (we && !ctrl_reset && wr != 5'd0) model[wr] = wd;
    @(negedge clock);
  endtask

  // Reset pulse; reads are checked while reset is held.
  task automatic pulse_reset();
    bus.ctrl_writeEnable = 1'b0;
    ctrl_reset = 1'b1;
    model_clear();
    for (int i = 0; i < 32; i += 4) begin
      bus.ctrl_readRegA = 5'(i + 3);
      bus.ctrl_readRegB = 5'(31 - i);
      #1;
      check("rst_held_a", bus.data_readRegA, 32'h0);
      check("rst_held_b", bus.data_readRegB, 32'h0);
    end
    @(negedge clock);
    ctrl_reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ctrl_reset = 1'b1;
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg = 5'd0;
    bus.ctrl_readRegA = 5'd0;
    bus.ctrl_readRegB = 5'd0;
    bus.data_writeReg = 32'h0;
    model_clear();

    // Scribble over the reset value first so the pulse has something to clear.
    @(negedge clock);
    ctrl_reset = 1'b0;
    for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), $urandom, 5'(i), 5'(i), "pre_fill");
    pulse_reset();
    for (int i = 0; i < 32; i++) begin
      bus.ctrl_readRegA = 5'(i);
      bus.ctrl_readRegB = 5'(i);
      #1;
      check("rst_sweep_a", bus.data_readRegA, 32'h0);
      check("rst_sweep_b", bus.data_readRegB, 32'h0);
    end
    @(negedge clock);

    // DEADBEEF into reg 5: old value before the edge, new value after on both ports.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, "wr5");
    check("wr5_model", model_read(5'd5), 32'hDEADBEEF);
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rd5");
    bus.ctrl_readRegA = 5'd5;
    #1;
    check("rd5_const", bus.data_readRegA, 32'hDEADBEEF);
    @(negedge clock);

    // Writes to reg 0 are dropped.
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "wr0");
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd0");

    // Write enable low: reg 7 keeps its value.
    cycle(1'b1, 5'd7, 32'hCAFE0007, 5'd7, 5'd7, "wr7");
    cycle(1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7, "we0");
    bus.ctrl_readRegA = 5'd7;
    #1;
    check("we0_const", bus.data_readRegA, 32'hCAFE0007);
    @(negedge clock);

    // Unique pattern in regs 1-31, then sweep A up and B down.
    for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'((i << 8) | i), 5'(i), 5'(32 - i), "uniq_wr");
    for (int i = 0; i < 32; i++) begin
      bus.ctrl_writeEnable = 1'b0;
      bus.ctrl_readRegA = 5'(i);
      bus.ctrl_readRegB = 5'(31 - i);
      #1;
      check("sweep_a", bus.data_readRegA, (i == 0) ? 32'h0 : 32'((i << 8) | i));
      check("sweep_b", bus.data_readRegB, (i == 31) ? 32'h0 : 32'(((31 - i) << 8) | (31 - i)));
    end
    @(negedge clock);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, 5'($urandom), 5'($urandom),
            "rand");
    end

    // Reset mid-cycle with a pending write to reg 9: reset wins.
    cycle(1'b1, 5'd9, 32'h0000ABCD, 5'd9, 5'd9, "ld9");
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg = 5'd9;
    bus.data_writeReg = 32'h11112222;
    bus.ctrl_readRegA = 5'd9;
    bus.ctrl_readRegB = 5'd9;
    #1;
    check("r9_before_rst", bus.data_readRegA, 32'h0000ABCD);
    ctrl_reset = 1'b1;
    model_clear();
    #1;
    check("r9_async_clr", bus.data_readRegA, 32'h0);
    @(posedge clock);
    @(negedge clock);
    check("r9_wr_lost", bus.data_readRegA, 32'h0);
    cycle(1'b1, 5'd9, 32'h55555555, 5'd9, 5'd9, "rst_held_wr");
    check("r9_held_b", bus.data_readRegB, 32'h0);
    ctrl_reset = 1'b0;
    // First write after reset release lands on the next edge.
    cycle(1'b1, 5'd9, 32'h77777777, 5'd9, 5'd9, "post_rst_wr");
    cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, "post_rst_rd");
    check("post_rst_model", model_read(5'd9), 32'h77777777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, setting the register and data-port width; REGS is fixed at 32 by the 5-bit register addresses.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all writes occur on its rising edge.
REQ-003 The block SHALL have port ctrl_reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port ctrl_writeEnable, input, 1, write request for the current cycle.
REQ-005 The block SHALL have port ctrl_writeReg, input, 5, write register index.
REQ-006 The block SHALL have port ctrl_readRegA, input, 5, read register index for port A, which feeds the ALU data_operandA.
REQ-007 The block SHALL have port ctrl_readRegB, input, 5, read register index for port B, which feeds the ALU data_operandB.
REQ-008 The block SHALL have port data_writeReg, input, DATA_WIDTH, write data (ALU data_result at writeback).
REQ-009 The block SHALL have port data_readRegA, output, DATA_WIDTH, contents of register ctrl_readRegA.
REQ-010 The block SHALL have port data_readRegB, output, DATA_WIDTH, contents of register ctrl_readRegB.
REQ-011 The block SHALL use one clock domain, with reset asynchronous and active-high exactly as stated above (clock, ctrl_reset).

Function
REQ-012 Storage SHALL be 32 registers of DATA_WIDTH bits each; registers 1-31 are writable.
REQ-013 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded.
REQ-014 Write SHALL occur at the rising clock edge when ctrl_writeEnable=1 and ctrl_reset=0; only register ctrl_writeReg is updated, with data_writeReg.
REQ-015 When ctrl_writeEnable=0, no register SHALL change at the edge, whatever the values on ctrl_writeReg and data_writeReg.
REQ-016 Reads SHALL be combinational with zero-cycle latency: data_readRegA/B follow the read index and the stored contents within the same cycle.
REQ-017 Same-cycle read and write of one index SHALL return the old value before the edge and the new value after it; there is no write-through bypass.
REQ-018 Both read ports SHALL work independently and at the same time, including when ctrl_readRegA equals ctrl_readRegB.
REQ-019 Outputs SHALL never be X or Z for any in-range index once reset has been applied.
REQ-020 Writes SHALL complete in a single cycle; there is no handshake, stall or back-pressure.

Reset
REQ-021 Asserting ctrl_reset SHALL clear all 32 registers to 0 immediately, without waiting for a clock edge.
REQ-022 While ctrl_reset=1, data_readRegA and data_readRegB SHALL read 0 for every index.
REQ-023 A write requested in a cycle where ctrl_reset=1 at the edge SHALL be discarded.
REQ-024 Reset asserted partway through a cycle that carries a pending write SHALL win: the write is lost and the register reads 0.
REQ-025 After ctrl_reset is deasserted, the first write SHALL take effect at the next rising edge.

Verification
REQ-026 Pulse ctrl_reset, then read all indices on both ports -> every read returns 32'h00000000.
REQ-027 Write 32'hDEADBEEF to reg 5; on the next cycle set readRegA=5 and readRegB=5 -> both ports return DEADBEEF. In the write cycle itself, readRegA=5 returns 00000000 before the edge.
REQ-028 Write 32'hFFFFFFFF to reg 0, then read reg 0 -> returns 00000000.
REQ-029 Set ctrl_writeEnable=0 with writeReg=7 and data=32'h12345678 over one edge -> reg 7 still reads its previous value.
REQ-030 Write a unique value (index<<8|index) to regs 1-31, then sweep readRegA upward and readRegB downward -> every read matches, with no aliasing between registers.
REQ-031 Load reg 9 with 32'h0000ABCD, assert ctrl_reset between clock edges -> data_readRegA at index 9 reads 0 before the next edge, and a write to reg 9 issued with reset held is not stored.
